// File: rtl/dsp_result_streamer.sv
// Captures the DSP result words after a settle delay and streams them out as a
// framed byte sequence: sync byte, then {index, 8 data bytes MSB first} per word.
module dsp_result_streamer #(
   parameter int         NUM_WORDS     = 5,
   parameter int         SETTLE_CYCLES = 16,
   parameter logic [7:0] SYNC_BYTE     = 8'h55
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [NUM_WORDS*64-1:0] prod_bus,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic                   busy,
   output logic                   done
);

   localparam int             CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [2:0]     LAST_IDX    = 3'(NUM_WORDS - 1);

   typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, SYNC, INDEX, DATA, DONE} state_t;

   state_t                  state;
   logic [CW-1:0]           settle_cnt;
   logic [NUM_WORDS*64-1:0] snapshot;
   logic [2:0]              idx;
   logic [2:0]              byte_cnt;
   logic [2:0]              next_byte;
   logic [63:0]             cur_word;
   logic                    accept;

   assign accept    = tx_valid & tx_ready;
   assign next_byte = byte_cnt + 3'd1;

   // Select the snapshot word currently being streamed.
   always_comb begin
      cur_word = '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
         if (idx == 3'(i)) cur_word = snapshot[64*i +: 64];
      end
   end

   // tx_data/tx_valid are loaded one step ahead so the next byte is ready the
   // cycle after an accept, giving one byte per cycle with no bubbles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         settle_cnt <= '0;
         snapshot   <= '0;
         idx        <= '0;
         byte_cnt   <= '0;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SETTLE;
                  settle_cnt <= '0;
                  busy       <= 1'b1;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) state <= CAPTURE;
               else settle_cnt <= settle_cnt + CW'(1);
            end
            CAPTURE: begin
               snapshot <= prod_bus;
               idx      <= '0;
               tx_data  <= SYNC_BYTE;
               tx_valid <= 1'b1;
               state    <= SYNC;
            end
            SYNC: begin
               if (accept) begin
                  tx_data <= {5'b0, idx};
                  state   <= INDEX;
               end
            end
            INDEX: begin
               if (accept) begin
                  tx_data  <= cur_word[63:56];
                  byte_cnt <= '0;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (accept) begin
                  if (byte_cnt == 3'd7) begin
                     if (idx == LAST_IDX) begin
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                        done     <= 1'b1;
                        state    <= DONE;
                     end else begin
                        idx     <= idx + 3'd1;
                        tx_data <= {5'b0, idx + 3'd1};
                        state   <= INDEX;
                     end
                  end else begin
                     byte_cnt <= next_byte;
                     tx_data  <= cur_word[{~next_byte, 3'b000} +: 8];
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
